// File: rtl/wide_add_seq.sv
// wide_add_seq: drives an external W-bit combinational adder one word per
// cycle (LSW first) to add two WORDS*W-bit operands, chaining the carry
// through a register and presenting the assembled sum and final carry.
module wide_add_seq #(
    parameter int W     = 32,
    parameter int WORDS = 4,
    parameter int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORDS*W-1:0]   a,
    input  logic [WORDS*W-1:0]   b,
    input  logic                 cin,
    output logic [W-1:0]         add_x1,
    output logic [W-1:0]         add_x2,
    output logic                 add_cin,
    input  logic [W-1:0]         add_s,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORDS*W-1:0]   sum,
    output logic                 cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

    state_t                     state;
    state_t                     state_next;
    logic [IDXW-1:0]            idx;
    logic                       carry;
    logic [WORDS-1:0][W-1:0]    a_reg;
    logic [WORDS-1:0][W-1:0]    b_reg;
    logic [WORDS-1:0][W-1:0]    sum_reg;
    logic                       cout_reg;

    // Handshake outputs come straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and adder drive; adder inputs are held at zero
    // outside RUN so the attached adder does not toggle needlessly.
    always_comb begin
        state_next = state;
        add_x1     = '0;
        add_x2     = '0;
        add_cin    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                add_x1  = a_reg[idx];
                add_x2  = b_reg[idx];
                add_cin = carry;
                if (idx == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, per-word result collection and carry chaining.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum_reg[idx] <= add_s;
                    carry        <= add_cout;
                    if (idx == LAST) begin
                        cout_reg <= add_cout;
                        idx      <= '0;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed and randomised bench for wide_add_seq with WORDS=4, 2 and 1,
// each instance paired with its own behavioural 32-bit adder.
module tb_wide_add_seq;

    logic         clk;
    logic         rst;
    logic [127:0] a_bus;
    logic [127:0] b_bus;
    logic         cin_bus;
    logic         in_valid  [3];
    logic         out_ready [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         cout_o    [3];
    logic [31:0]  x1 [3];
    logic [31:0]  x2 [3];
    logic         xc [3];
    logic [31:0]  s  [3];
    logic         co [3];
    logic [127:0] sum4;
    logic [63:0]  sum2;
    logic [31:0]  sum1;

    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural adders attached to each instance.
    for (genvar k = 0; k < 3; k++) begin : g_add
        assign {co[k], s[k]} = {1'b0, x1[k]} + {1'b0, x2[k]} + {32'b0, xc[k]};
    end

    wide_add_seq #(.W(32), .WORDS(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_bus), .b(b_bus), .cin(cin_bus),
        .add_x1(x1[0]), .add_x2(x2[0]), .add_cin(xc[0]),
        .add_s(s[0]), .add_cout(co[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum4), .cout(cout_o[0])
    );

    wide_add_seq #(.W(32), .WORDS(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_bus[63:0]), .b(b_bus[63:0]), .cin(cin_bus),
        .add_x1(x1[1]), .add_x2(x2[1]), .add_cin(xc[1]),
        .add_s(s[1]), .add_cout(co[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum2), .cout(cout_o[1])
    );

    wide_add_seq #(.W(32), .WORDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_bus[31:0]), .b(b_bus[31:0]), .cin(cin_bus),
        .add_x1(x1[2]), .add_x2(x2[2]), .add_cin(xc[2]),
        .add_s(s[2]), .add_cout(co[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum1), .cout(cout_o[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] get_sum(input int k);
        case (k)
            0:       return sum4;
            1:       return {64'b0, sum2};
            default: return {96'b0, sum1};
        endcase
    endfunction

    function automatic int words_of(input int k);
        case (k)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    // Launch one operation on instance k, wait for its result and then
    // release it with (optionally random) out_ready backpressure.
    task automatic do_op(input int k, input logic [127:0] ia, input logic [127:0] ib,
                         input logic ic, input bit rnd_ready,
                         output logic [127:0] os, output logic oc, output bit ok);
        a_bus       = ia;
        b_bus       = ib;
        cin_bus     = ic;
        in_valid[k] = 1'b1;
        tick();
        in_valid[k] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid[k]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        os = get_sum(k);
        oc = cout_o[k];
        if (ok) begin
            for (int i = 0; i < 40; i++) begin
                out_ready[k] = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (i == 39) out_ready[k] = 1'b1;
                tick();
                if (out_ready[k]) break;
            end
            out_ready[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
        end
        a_bus = '0; b_bus = '0; cin_bus = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks += 7;
        if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready[0]); end
        if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid[0]); end
        if (sum4 !== 128'd0) begin n_fail++; $display("FAIL reset_sum got %h exp 0", sum4); end
        if (cout_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b exp 0", cout_o[0]); end
        if (x1[0] !== 32'd0) begin n_fail++; $display("FAIL reset_add_x1 got %h exp 0", x1[0]); end
        if (x2[0] !== 32'd0) begin n_fail++; $display("FAIL reset_add_x2 got %h exp 0", x2[0]); end
        if (xc[0] !== 1'b0) begin n_fail++; $display("FAIL reset_add_cin got %b exp 0", xc[0]); end
    endtask

    // Walks the RUN cycles of instance 0 checking the adder carry-in sequence.
    task automatic test_ripple();
        logic [3:0] exp_cin;
        logic [31:0] exp_x2;
        exp_cin = 4'b1110;
        n_checks++;
        if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL ripple_ready_pre got %b exp 1", in_ready[0]); end
        a_bus = '1; b_bus = 128'd1; cin_bus = 1'b0;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_x2 = (i == 0) ? 32'd1 : 32'd0;
            n_checks += 4;
            if (xc[0] !== exp_cin[i]) begin n_fail++; $display("FAIL ripple_add_cin[%0d] got %b exp %b", i, xc[0], exp_cin[i]); end
            if (x1[0] !== 32'hffff_ffff) begin n_fail++; $display("FAIL ripple_add_x1[%0d] got %h exp ffffffff", i, x1[0]); end
            if (x2[0] !== exp_x2) begin n_fail++; $display("FAIL ripple_add_x2[%0d] got %h exp %h", i, x2[0], exp_x2); end
            if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL ripple_early_valid[%0d] got %b exp 0", i, out_valid[0]); end
            tick();
        end
        n_checks += 5;
        if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL ripple_out_valid got %b exp 1", out_valid[0]); end
        if (sum4 !== 128'd0) begin n_fail++; $display("FAIL ripple_sum got %h exp 0", sum4); end
        if (cout_o[0] !== 1'b1) begin n_fail++; $display("FAIL ripple_cout got %b exp 1", cout_o[0]); end
        if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL ripple_in_ready_done got %b exp 0", in_ready[0]); end
        if (x1[0] !== 32'd0) begin n_fail++; $display("FAIL ripple_done_add_x1 got %h exp 0", x1[0]); end
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        n_checks += 2;
        if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL ripple_release_valid got %b exp 0", out_valid[0]); end
        if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL ripple_release_ready got %b exp 1", in_ready[0]); end
    endtask

    task automatic test_cin_only();
        logic [3:0] exp_cin;
        exp_cin = 4'b0001;
        a_bus = '0; b_bus = '0; cin_bus = 1'b1;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (xc[0] !== exp_cin[i]) begin n_fail++; $display("FAIL cin_add_cin[%0d] got %b exp %b", i, xc[0], exp_cin[i]); end
            tick();
        end
        n_checks += 3;
        if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL cin_out_valid got %b exp 1", out_valid[0]); end
        if (sum4 !== 128'd1) begin n_fail++; $display("FAIL cin_sum got %h exp 1", sum4); end
        if (cout_o[0] !== 1'b0) begin n_fail++; $display("FAIL cin_cout got %b exp 0", cout_o[0]); end
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [127:0] exp_s;
        logic [127:0] got_s;
        logic         got_c;
        bit           ok;
        exp_s = 128'h00000001_ffffffff_00000001_00000000;
        a_bus = 128'h00000001_ffffffff_00000000_ffffffff;
        b_bus = 128'd1;
        cin_bus = 1'b0;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (4) tick();
        a_bus = 128'd5; b_bus = 128'd7; cin_bus = 1'b1;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks += 4;
            if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d] got %b exp 1", i, out_valid[0]); end
            if (in_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready[0]); end
            if (sum4 !== exp_s) begin n_fail++; $display("FAIL bp_sum[%0d] got %h exp %h", i, sum4, exp_s); end
            if (cout_o[0] !== 1'b0) begin n_fail++; $display("FAIL bp_cout[%0d] got %b exp 0", i, cout_o[0]); end
            tick();
        end
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        n_checks += 3;
        if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b exp 0", out_valid[0]); end
        if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", in_ready[0]); end
        if (sum4 !== exp_s) begin n_fail++; $display("FAIL bp_sum_held got %h exp %h", sum4, exp_s); end
        in_valid[0] = 1'b0;
        do_op(0, 128'd5, 128'd7, 1'b1, 1'b0, got_s, got_c, ok);
        n_checks += 3;
        if (!ok) begin n_fail++; $display("FAIL bp_next_timeout got 0 exp 1"); end
        if (got_s !== 128'd13) begin n_fail++; $display("FAIL bp_next_sum got %h exp d", got_s); end
        if (got_c !== 1'b0) begin n_fail++; $display("FAIL bp_next_cout got %b exp 0", got_c); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] got_s;
        logic         got_c;
        bit           ok;
        a_bus = '1; b_bus = 128'd1; cin_bus = 1'b0;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (2) tick();
        #1 rst = 1'b1;
        #1;
        n_checks += 5;
        if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready got %b exp 1", in_ready[0]); end
        if (out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid got %b exp 0", out_valid[0]); end
        if (xc[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_add_cin got %b exp 0", xc[0]); end
        if (x1[0] !== 32'd0) begin n_fail++; $display("FAIL mid_rst_add_x1 got %h exp 0", x1[0]); end
        if (sum4 !== 128'd0) begin n_fail++; $display("FAIL mid_rst_sum got %h exp 0", sum4); end
        tick();
        rst = 1'b0;
        do_op(0, 128'd5, 128'd3, 1'b0, 1'b0, got_s, got_c, ok);
        n_checks += 3;
        if (!ok) begin n_fail++; $display("FAIL mid_rst_timeout got 0 exp 1"); end
        if (got_s !== 128'd8) begin n_fail++; $display("FAIL mid_rst_sum8 got %h exp 8", got_s); end
        if (got_c !== 1'b0) begin n_fail++; $display("FAIL mid_rst_cout got %b exp 0", got_c); end
    endtask

    task automatic test_back_to_back(input int k, input int n);
        logic [127:0] mask;
        logic [127:0] ia;
        logic [127:0] ib;
        logic         ic;
        logic [128:0] full;
        logic [127:0] got_s;
        logic         got_c;
        bit           ok;
        int           nbits;
        nbits = 32 * words_of(k);
        mask  = (nbits == 128) ? '1 : ((128'd1 << nbits) - 128'd1);
        for (int i = 0; i < n; i++) begin
            ia = {$urandom, $urandom, $urandom, $urandom};
            ib = {$urandom, $urandom, $urandom, $urandom};
            if (i % 8 == 3) ia = '1;
            if (i % 8 == 5) ib = ~ia;
            ia = ia & mask;
            ib = ib & mask;
            ic = ($urandom_range(0, 1) == 1);
            full = {1'b0, ia} + {1'b0, ib} + {128'd0, ic};
            n_checks++;
            if (in_ready[k] !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_ready[%0d] got %b exp 1", words_of(k), i, in_ready[k]); end
            do_op(k, ia, ib, ic, 1'b1, got_s, got_c, ok);
            n_checks += 3;
            if (!ok) begin n_fail++; $display("FAIL b2b%0d_timeout[%0d] got 0 exp 1", words_of(k), i); end
            if (got_s !== (full[127:0] & mask)) begin
                n_fail++;
                $display("FAIL b2b%0d_sum[%0d] got %h exp %h", words_of(k), i, got_s, full[127:0] & mask);
            end
            if (got_c !== full[nbits]) begin
                n_fail++;
                $display("FAIL b2b%0d_cout[%0d] got %b exp %b", words_of(k), i, got_c, full[nbits]);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_ripple();
        test_cin_only();
        test_backpressure();
        test_reset_mid();
        test_back_to_back(0, 1000);
        test_back_to_back(1, 1000);
        test_back_to_back(2, 1000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wide_add_seq.md
Name: wide_add_seq

Overview:
- Sequencer for multi-word additions wider than the 32-bit adder datapath.
- Sits directly upstream and downstream of one 32-bit combinational adder instance (x1/x2/cin in, s/cout out).
- Accepts a WORDS*W-bit operand pair over a valid/ready handshake and feeds the adder one W-bit word per cycle, LSW first.
- Chains each word's carry through a register, then returns the assembled sum and final carry over a valid/ready handshake.

Parameters:
- W, 32, adder word width; must match the attached adder.
- WORDS, 4, number of words per operand; total width WORDS*W; WORDS >= 1.
- IDXW, clog2(WORDS) (1 when WORDS=1), width of the word index counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  WORDS*W  operand A.
- b  input  WORDS*W  operand B.
- cin  input  1  carry-in for word 0.
- add_x1  output  W  to adder x1.
- add_x2  output  W  to adder x2.
- add_cin  output  1  to adder cin.
- add_s  input  W  from adder s; combinational same cycle.
- add_cout  input  1  from adder cout.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WORDS*W  result, A + B + cin modulo 2^(WORDS*W).
- cout  output  1  carry out of the most significant word.

Behaviour:
- Reset (async, any state): state=IDLE; idx=0; carry reg=0; a/b/sum regs=0; cout=0; out_valid=0; in_ready=1 (in_ready = state==IDLE). Any in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a rising edge: capture a, b into regs; carry<=cin; idx<=0; go to RUN.
- RUN:
  - in_ready=0; out_valid=0.
  - add_x1=a_reg word[idx], add_x2=b_reg word[idx], add_cin=carry.
  - Each edge: sum word[idx]<=add_s; carry<=add_cout; idx<=idx+1.
  - At idx==WORDS-1: also cout<=add_cout; go to DONE; idx<=0 (no wrap past WORDS-1).
- DONE:
  - out_valid=1; sum and cout held stable.
  - in_ready=0; in_valid ignored.
  - On out_ready at an edge: go to IDLE; out_valid=0 next cycle.
- Adder drive outside RUN: add_x1=0, add_x2=0, add_cin=0, to suppress switching activity.
- Latency: accept edge E -> out_valid high after edge E+WORDS. With out_ready held high, in_ready returns after edge E+WORDS+1; minimum spacing between accepts is WORDS+2 cycles.
- sum and cout keep their value after DONE->IDLE until overwritten word by word by the next operation. Consumers qualify them only by out_valid.
- WORDS=1: a single RUN cycle, then DONE.
- Unused word index values are unreachable (idx < WORDS always).
- All outputs except the add_* drives come directly from registers or state. add_* are muxes off registers, with no combinational path from add_s/add_cout back to the add_* outputs.
- Arithmetic is unsigned; overflow is reported only through cout.

Test Plan:
- Reset: hold rst 3 cycles, release -> in_ready=1, out_valid=0, sum=0, cout=0, add_x1=add_x2=0, add_cin=0.
- Full carry ripple (WORDS=4): a=2^128-1, b=1, cin=0, accept at edge E -> add_cin=0,1,1,1 across the RUN cycles; out_valid rises after E+4; sum=0, cout=1.
- Cin only: a=0, b=0, cin=1 -> sum=1, cout=0; add_cin=1 only in the first RUN cycle.
- Backpressure: complete an op with out_ready=0 for 5 cycles and in_valid=1 with new operands -> out_valid stays 1, sum/cout stable, in_ready=0, new operands not captured. Then out_ready=1 -> IDLE; next accept yields the new result.
- Reset mid-op: assert rst after 2 RUN cycles -> immediately IDLE, out_valid=0, carry=0. Then a=0x...0005, b=0x...0003 -> sum=8, cout=0.
- Random back-to-back: 1000 random a/b/cin pairs with random out_ready, compared against a WORDS*W+1-bit reference sum. Repeat with WORDS=1 and WORDS=2.
